// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter and fetch sequencer for a 16-bit word-addressed core.
//   Each update cycle selects the next pc (jump > branch > sequential),
//   counts retired instructions with saturation, and stops in HALT when
//   the fetched word equals HALT_INSTR. Only reset leaves HALT.
//
// Ports
//   clk            in   1   rising-edge clock
//   reset          in   1   synchronous, active-high reset
//   en             in   1   advance enable (0 = stall)
//   branch         in   1   taken conditional branch
//   branch_offset  in  16   sign-extended word offset
//   jump           in   1   unconditional jump
//   jump_target    in  12   word-address field of the jump
//   instruction    in  16   word fetched at pc
//   pc             out 16   registered byte address (bit 0 always 0)
//   pc_plus2       out 16   pc + 2, modulo 2^16
//   state          out  2   RUN=00, STALL=01, HALT=10
//   halted         out  1   high exactly when state is HALT
//   instr_count    out 16   saturating retired-instruction count
module pc_fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] HALT_INSTR = 16'hF000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        branch,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [11:0] jump_target,
  input  logic [15:0] instruction,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic [1:0]  state,
  output logic        halted,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    HALT  = 2'b10
  } state_t;

  state_t state_q;

  logic signed [15:0] offset_s;
  logic signed [15:0] offset_bytes;
  logic        [15:0] branch_pc;
  logic        [15:0] jump_pc;
  logic        [15:0] next_pc;

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end
    return value + 16'd1;
  endfunction

  assign pc_plus2 = pc + 16'd2;

  // Word offset becomes a byte offset; the shift keeps bit 0 clear so the
  // branch target stays halfword aligned, and the add wraps silently.
  assign offset_s     = branch_offset;
  assign offset_bytes = offset_s <<< 1;
  assign branch_pc    = pc_plus2 + $unsigned(offset_bytes);

  // Jump keeps the 8 KiB region of the sequential successor.
  assign jump_pc = {pc_plus2[15:13], jump_target, 1'b0};

  always_comb begin
    next_pc = pc_plus2;
    if (jump) begin
      next_pc = jump_pc;
    end else if (branch) begin
      next_pc = branch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= {RESET_PC[15:1], 1'b0};
      instr_count <= 16'd0;
      state_q     <= RUN;
      halted      <= 1'b0;
    end else begin
      case (state_q)
        RUN, STALL: begin
          if (en) begin
            if (instruction == HALT_INSTR) begin
              state_q <= HALT;
              halted  <= 1'b1;
            end else begin
              pc          <= next_pc;
              instr_count <= sat_inc(instr_count);
              state_q     <= RUN;
            end
          end else begin
            state_q <= STALL;
          end
        end
        // HALT ignores every input so X on them cannot leak into outputs.
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, byte address loaded into pc on reset; bit 0 is forced to 0.
REQ-002 Parameter HALT_INSTR, default 16'hF000, instruction word that stops fetching.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  advance enable; 0 holds pc (stall).
REQ-006 branch  input  1  taken conditional branch (beq with ALU zero), from control.
REQ-007 branch_offset  input  16  sign-extended word offset from the instruction immediate.
REQ-008 jump  input  1  unconditional jump, from control.
REQ-009 jump_target  input  12  word-address field of the jump instruction.
REQ-010 instruction  input  16  word currently returned by instruction memory for pc.
REQ-011 pc  output  16  registered byte address driven to instruction memory; word index is pc[4:1].
REQ-012 pc_plus2  output  16  combinational pc + 2, modulo 2^16.
REQ-013 state  output  2  RUN=2'b00, STALL=2'b01, HALT=2'b10.
REQ-014 halted  output  1  1 when and only when state is HALT.
REQ-015 instr_count  output  16  registered count of instructions retired.

Function
REQ-016 An update cycle is any rising edge with reset=0, state RUN or STALL, and en=1.
REQ-017 Branch target is pc + 2 + (branch_offset << 1), truncated to 16 bits.
REQ-018 Jump target is {pc_plus2[15:13], jump_target, 1'b0}.
REQ-019 Next-pc priority in an update cycle: halt (no change) > jump > branch > pc_plus2.
REQ-020 If jump and branch are both 1, jump wins and the branch is ignored.
REQ-021 In an update cycle where instruction equals HALT_INSTR, pc holds, instr_count does not increment, and state becomes HALT.
REQ-022 In any other update cycle, pc takes the selected next pc, instr_count increments by 1, and state becomes RUN.
REQ-023 instr_count saturates at 16'hFFFF.
REQ-024 In RUN with en=0, pc and instr_count hold and state becomes STALL.
REQ-025 In STALL with en=0, everything holds.
REQ-026 In STALL with en=1, the edge is a normal update cycle, so the resume adds no latency.
REQ-027 HALT is absorbing: pc, instr_count and state hold regardless of en, branch or jump, and only reset exits HALT.
REQ-028 pc advances with one-cycle latency: the next pc selected in cycle N appears on pc after the edge ending cycle N.
REQ-029 pc bit 0 is 0 at all times.
REQ-030 pc wraps from 16'hFFFE to 16'h0000 on a sequential advance.
REQ-031 Branch and jump targets wrap modulo 2^16 with no error indication.
REQ-032 Inputs that are X while state is HALT do not affect any output.

Reset
REQ-033 On a rising edge with reset=1: pc=RESET_PC with bit 0 cleared, instr_count=0, state=RUN, halted=0.
REQ-034 Reset has priority over en, branch, jump and halt detection.
REQ-035 Reset asserted mid-stall or in HALT takes effect at that edge.
REQ-036 Outputs are defined from the first edge at which reset is sampled high.

Verification
REQ-037 Sequential: reset, then en=1 for 5 cycles with non-halt instructions -> pc steps 0,2,4,6,8,A and instr_count=5.
REQ-038 Branch and jump:
- At pc=4, branch=1 with branch_offset=16'h0002 -> next pc=16'h000A.
- At pc=16'h000A, branch_offset=16'hFFFD -> next pc=16'h0006.
- At pc=4, jump=1 and branch=1 with jump_target=12'h005 -> next pc=16'h000A; the jump wins.
REQ-039 Stall: at pc=6, en=0 for 3 cycles -> pc stays 6, state=STALL, count frozen; then en=1 -> pc=8 on the next edge and state=RUN.
REQ-040 Halt:
- At pc=16'h000C with instruction=16'hF000 -> state=HALT, halted=1, pc stays 16'h000C.
- Further en, branch and jump pulses are ignored.
- reset -> pc=0, count=0.
REQ-041 Wrap and saturation:
- RESET_PC=16'hFFFC -> pc goes FFFC, FFFE, 0000.
- Force instr_count to FFFF -> it stays FFFF after further update cycles.
REQ-042 Reset mid-operation: reset pulsed in the same cycle as jump=1, en=1 in RUN -> pc=RESET_PC and state=RUN after that edge.
